rect_render_engine: RTL

- Parametrised rectangle rasteriser for the VGA drawing path.
- Accepts origin, width, height, colour and mode on a start strobe.
- Emits one pixel coordinate per clock, with a plot strobe for the VGA adapter, in raster order.
- Supports filled and outline rectangles of runtime size, with busy/done handshake to the controlling FSM.

---
 rtl/rect_render_engine.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/rect_render_engine.sv
// rect_render_engine: rectangle rasteriser for the VGA drawing path.
// Scans a w x h rectangle in raster order, one pixel per clock, and emits a
// registered coordinate, colour and plot strobe for each scanned position.
// Filled or outline mode; interior pixels of an outline still take a clock.
//
// Optional build macro: RECT_CLIP_EN -- suppress plot for pixels whose
// unwrapped coordinate falls outside SCREEN_W x SCREEN_H.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   start                request strobe, honoured only in IDLE
//   x_in, y_in           top-left origin
//   w_in, h_in           rectangle size in pixels (0 => empty request)
//   colour_in, outline   draw colour, 1 = outline only
//   r_x, r_y, colour_out registered pixel coordinate and colour
//   plot                 registered VGA write enable
//   busy                 high for each scanned pixel cycle
//   done                 one-cycle completion pulse
module rect_render_engine #(
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned DIM_W    = 4,
  parameter int unsigned COL_W    = 3,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [X_W-1:0]   x_in,
  input  logic [Y_W-1:0]   y_in,
  input  logic [DIM_W-1:0] w_in,
  input  logic [DIM_W-1:0] h_in,
  input  logic [COL_W-1:0] colour_in,
  input  logic             outline,
  output logic [X_W-1:0]   r_x,
  output logic [Y_W-1:0]   r_y,
  output logic [COL_W-1:0] colour_out,
  output logic             plot,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FIN = 2'd2} state_t;

  state_t state, state_nxt;

  logic [X_W-1:0]   x0;
  logic [Y_W-1:0]   y0;
  logic [DIM_W-1:0] w_r, h_r, cx, cy;
  logic [COL_W-1:0] col_r;
  logic             outline_r;

  logic [X_W-1:0]   rx_d;
  logic [Y_W-1:0]   ry_d;
  logic [COL_W-1:0] col_d;
  logic             plot_d, busy_d, done_d;

  // A start seen while done is still high is dropped: the pulse cycle
  // counts as the tail of the previous request.
  logic accept_c, zero_size_c, row_end_c, col_end_c, last_c, border_c;
  assign accept_c    = (state == IDLE) && start && !done;
  assign zero_size_c = (w_in == '0) || (h_in == '0);
  assign row_end_c   = (cx == w_r - DIM_W'(1));
  assign col_end_c   = (cy == h_r - DIM_W'(1));
  assign last_c      = row_end_c && col_end_c;
  assign border_c    = (cx == '0) || row_end_c || (cy == '0) || col_end_c;

  // Pixel address and on-screen test
  logic [X_W-1:0] x_sum_c;
  logic [Y_W-1:0] y_sum_c;
  logic           in_screen_c;
`ifdef RECT_CLIP_EN
  logic [X_W:0] x_full_c;
  logic [Y_W:0] y_full_c;
  assign x_full_c    = {1'b0, x0} + (X_W+1)'(cx);
  assign y_full_c    = {1'b0, y0} + (Y_W+1)'(cy);
  assign x_sum_c     = x_full_c[X_W-1:0];
  assign y_sum_c     = y_full_c[Y_W-1:0];
  assign in_screen_c = (x_full_c < (X_W+1)'(SCREEN_W)) &&
                       (y_full_c < (Y_W+1)'(SCREEN_H));
`else
  logic unused_clip;
  assign x_sum_c     = x0 + X_W'(cx);
  assign y_sum_c     = y0 + Y_W'(cy);
  assign in_screen_c = 1'b1;
  assign unused_clip = ^{X_W'(SCREEN_W), Y_W'(SCREEN_H)};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept_c) state_nxt = zero_size_c ? FIN : SCAN;
      SCAN: if (last_c)   state_nxt = FIN;
      FIN:                state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  // Output next-values; coordinates and colour hold outside SCAN
  always_comb begin
    rx_d   = r_x;
    ry_d   = r_y;
    col_d  = colour_out;
    plot_d = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state)
      SCAN: begin
        rx_d   = x_sum_c;
        ry_d   = y_sum_c;
        col_d  = col_r;
        busy_d = 1'b1;
        plot_d = (!outline_r || border_c) && in_screen_c;
      end
      FIN:     done_d = 1'b1;
      default: ;
    endcase
  end

  // Request latch and raster counters
  always_ff @(posedge clk) begin
    if (!resetn) begin
      x0        <= '0;
      y0        <= '0;
      w_r       <= '0;
      h_r       <= '0;
      col_r     <= '0;
      outline_r <= 1'b0;
      cx        <= '0;
      cy        <= '0;
    end else if (accept_c) begin
      x0        <= x_in;
      y0        <= y_in;
      w_r       <= w_in;
      h_r       <= h_in;
      col_r     <= colour_in;
      outline_r <= outline;
      cx        <= '0;
      cy        <= '0;
    end else if (state == SCAN) begin
      if (row_end_c) begin
        cx <= '0;
        cy <= cy + DIM_W'(1);
      end else begin
        cx <= cx + DIM_W'(1);
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_x        <= '0;
      r_y        <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_x        <= rx_d;
      r_y        <= ry_d;
      colour_out <= col_d;
      plot       <= plot_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule
